// File: rtl/clock_div_if.sv
// Control/status bundle for clock_div: ratio programming, enable and divided-clock outputs.
// The sync_in realign signal exists only when CLKDIV_SYNC_EN is defined.
interface clock_div_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
  logic             div_busy;
  logic             div_err;
  logic [CNT_W-1:0] div_cur;
  logic             clk_out;
  logic             tick;
`ifdef CLKDIV_SYNC_EN
  logic             sync_in;

  modport master (
    output en, div_in, div_load, sync_in,
    input  div_busy, div_err, div_cur, clk_out, tick
  );
  modport slave (
    input  en, div_in, div_load, sync_in,
    output div_busy, div_err, div_cur, clk_out, tick
  );
`else
  modport master (
    output en, div_in, div_load,
    input  div_busy, div_err, div_cur, clk_out, tick
  );
  modport slave (
    input  en, div_in, div_load,
    output div_busy, div_err, div_cur, clk_out, tick
  );
`endif
endinterface

// File: rtl/clock_div.sv
// Runtime-programmable clock divider: registered clk_out, tick strobe, glitch-free ratio change.
// Optional phase realign input enabled by macro CLKDIV_SYNC_EN.
module clock_div #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  clock_div_if.slave  bus
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic             load_ok;
  logic             at_boundary;
  logic             wrap;
  logic [CNT_W:0]   half_d;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d       = cnt_q;
    div_cur_d   = div_cur_q;
    pend_d      = pend_q;
    busy_d      = busy_q;
    load_ok     = bus.en && bus.div_load && (bus.div_in >= MIN_DIV);
    err_d       = bus.en && bus.div_load && (bus.div_in < MIN_DIV);
    at_boundary = bus.en && (cnt_q == div_cur_q - ONE);
`ifdef CLKDIV_SYNC_EN
    wrap        = at_boundary || bus.sync_in;
`else
    wrap        = at_boundary;
`endif

    if (load_ok) begin
      pend_d = bus.div_in;
      busy_d = 1'b1;
    end

    // A load arriving in the wrap cycle goes straight to div_cur instead of waiting a period.
    if (wrap) begin
      cnt_d  = '0;
      busy_d = 1'b0;
      if (load_ok) begin
        div_cur_d = bus.div_in;
      end else if (busy_q) begin
        div_cur_d = pend_q;
      end
    end else if (bus.en) begin
      cnt_d = cnt_q + ONE;
    end

    // One extra bit keeps (N+1)>>1 exact at the largest ratio.
    half_d    = ({1'b0, div_cur_d} + (CNT_W+1)'(1)) >> 1;
    clk_out_d = ({1'b0, cnt_d} >= half_d);
    tick_d    = bus.en && ({1'b0, cnt_d} == half_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      div_cur_q <= DEF_DIV;
      pend_q    <= DEF_DIV;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.div_busy = busy_q;
  assign bus.div_err  = err_q;
  assign bus.div_cur  = div_cur_q;
  assign bus.clk_out  = clk_out_q;
  assign bus.tick     = tick_q;

endmodule

// File: tb/tb_clock_div.sv
// Self-checking bench for clock_div: directed scenarios plus randomized traffic against
// a period/position reference model with a one-deep pending queue.
module tb_clock_div;

  localparam int CNT_W = 8;
  localparam int DEF   = 4;

  logic clk;
  logic reset;
  clock_div_if #(.CNT_W(CNT_W)) bus ();

  clock_div #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: position inside the current period, active ratio, pending ratios.
  int m_pos;
  int m_n;
  int m_pend[$];
  bit m_err;
  bit m_clk;
  bit m_tick;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".clk_out"},  32'(bus.clk_out),  32'(m_clk));
    check({tag, ".tick"},     32'(bus.tick),     32'(m_tick));
    check({tag, ".div_cur"},  32'(bus.div_cur),  32'(m_n));
    check({tag, ".div_busy"}, 32'(bus.div_busy), 32'(m_pend.size() != 0));
    check({tag, ".div_err"},  32'(bus.div_err),  32'(m_err));
  endtask

  task automatic model_reset();
    m_pos = 0; m_n = DEF; m_pend.delete();
    m_err = 0; m_clk = 0; m_tick = 0;
  endtask

  function automatic void model_step(bit en, bit ld, int din, bit sy);
    bit ok  = en && ld && din >= 2;
    bit bad = en && ld && din < 2;
    bit wr  = (en && m_pos == m_n - 1) || sy;
    m_err = bad;
    if (ok && !wr) begin
      m_pend.delete();
      m_pend.push_back(din);
    end
    if (wr) begin
      if (ok) m_n = din;
      else if (m_pend.size() != 0) m_n = m_pend.pop_front();
      m_pend.delete();
      m_pos = 0;
    end else if (en) begin
      m_pos++;
    end
    m_clk  = m_pos >= (m_n + 1) / 2;
    m_tick = en && m_pos == (m_n + 1) / 2;
  endfunction

  // Drive inputs at the falling edge, advance one rising edge, sample at the next falling edge.
  task automatic step(input bit en, input bit ld, input int din, input bit sy, input string tag);
    bus.en       = en;
    bus.div_load = ld;
    bus.div_in   = CNT_W'(din);
`ifdef CLKDIV_SYNC_EN
    bus.sync_in  = sy;
`endif
    model_step(en, ld, din, sy);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in   = '0;
`ifdef CLKDIV_SYNC_EN
    bus.sync_in  = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int din;
    bit en, ld, sy;

    // Reset state and the default divide-by-4 waveform.
    do_reset();
    check_all("reset");
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 0, 0, "n4");
      check("n4_pattern_clk",  32'(bus.clk_out), 32'((k % 4) >= 2));
      check("n4_pattern_tick", 32'(bus.tick),    32'((k % 4) == 2));
    end

    // Load 5 at cnt=1; applied at the following period boundary.
    do_reset();
    step(1, 1, 5, 0, "load5_req");
    check("load5_busy", 32'(bus.div_busy), 32'd1);
    for (int k = 0; k < 14; k++) step(1, 0, 0, 0, "load5");
    check("load5_cur", 32'(bus.div_cur), 32'd5);

    // Latest of two pending loads wins.
    do_reset();
    step(1, 1, 7, 0, "ow_a");
    step(1, 1, 3, 0, "ow_b");
    for (int k = 0; k < 8; k++) step(1, 0, 0, 0, "ow");
    check("ow_cur", 32'(bus.div_cur), 32'd3);

    // Rejected ratios pulse div_err and change nothing.
    step(1, 1, 1, 0, "err1");
    check("err1_pulse", 32'(bus.div_err), 32'd1);
    step(1, 1, 0, 0, "err0");
    step(1, 0, 0, 0, "err_clear");
    check("err_clear_pulse", 32'(bus.div_err), 32'd0);

    // Enable low mid-period holds clk_out high at cnt=2 of N=4.
    do_reset();
    step(1, 0, 0, 0, "hold_pre");
    step(1, 0, 0, 0, "hold_pre");
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, "hold");
      check("hold_clk_out", 32'(bus.clk_out), 32'd1);
    end
    step(1, 0, 0, 0, "hold_resume");
    step(1, 0, 0, 0, "hold_resume");
    check("hold_wrap_clk", 32'(bus.clk_out), 32'd0);

    // Reset discards a pending ratio.
    step(1, 1, 9, 0, "rst_pend");
    do_reset();
    check_all("rst_pend_after");

    // Load exactly in the boundary cycle is applied without going busy.
    step(1, 0, 0, 0, "bnd");
    step(1, 0, 0, 0, "bnd");
    step(1, 0, 0, 0, "bnd");
    step(1, 1, 6, 0, "bnd_load");
    check("bnd_cur", 32'(bus.div_cur), 32'd6);

`ifdef CLKDIV_SYNC_EN
    // Realign at cnt=1 with pending 6 applies it at once.
    do_reset();
    step(1, 1, 6, 0, "sync_load");
    step(1, 0, 0, 1, "sync");
    check("sync_cur", 32'(bus.div_cur), 32'd6);
    for (int k = 0; k < 8; k++) step(1, 0, 0, 0, "sync_after");
`endif

    // Randomized traffic, including the largest legal ratio once in a while.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      en = ($urandom_range(0, 7) != 0);
      ld = en && ($urandom_range(0, 15) == 0);
      din = ($urandom_range(0, 40) == 0) ? 255 : int'($urandom_range(0, 12));
`ifdef CLKDIV_SYNC_EN
      sy = ($urandom_range(0, 63) == 0);
`else
      sy = 1'b0;
`endif
      step(en, ld, din, sy, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_div.md
# clock_div

Parametrised, runtime-programmable clock divider. It generates a divided clock-like signal `clk_out` and a one-cycle `tick` strobe from the system clock. The divide ratio can be reprogrammed on the fly, and a new ratio is applied glitch-free at a period boundary. It sits beside the processor/memory clocking logic and generalises the fixed divide-by-4 generator, so any slower domain or clock-enable can be derived from a single block.

## Interface
Parameters:
- CNT_W, 8: width of the ratio and counter; legal ratio N is 2..2^CNT_W-1.
- DEFAULT_DIV, 4: ratio loaded on reset; must be at least 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- en  in  1  count enable; when low, all state holds.
- div_in  in  CNT_W  requested ratio N.
- div_load  in  1  one-cycle request to load `div_in`.
- div_busy  out  1  a loaded ratio is pending and not yet applied.
- div_err  out  1  one-cycle pulse: a load was rejected because `div_in` < 2.
- div_cur  out  CNT_W  ratio currently in effect.
- clk_out  out  1  divided output, registered.
- tick  out  1  one-cycle pulse coincident with each rising edge of `clk_out`.
- sync_in  in  1  phase realign; present only with CLKDIV_SYNC_EN.

## Operation
- State:
  - counter `cnt` (CNT_W bits), range 0..N-1;
  - `div_cur`;
  - pending register plus pending flag (`div_busy`).
- Reset (reset==0 at a posedge):
  - cnt=0, clk_out=0, tick=0;
  - div_cur=DEFAULT_DIV, div_busy=0, div_err=0.
- Counting, per cycle with en=1:
  - cnt increments;
  - at cnt==N-1 it wraps to 0; this is the period boundary.
- clk_out is 0 while cnt < ceil(N/2), and 1 while cnt >= ceil(N/2).
  - Even N: 50% duty.
  - Odd N: low phase is one cycle longer.
- tick is 1 exactly in the cycle where cnt == ceil(N/2), i.e. the first high cycle of clk_out.
- en=0: cnt, clk_out and the pending state hold; tick=0.
- Load handling:
  - div_load with div_in >= 2 writes the pending register and sets div_busy.
  - A further load while busy overwrites the pending value; the latest load wins.
  - div_load with div_in < 2: rejected, pending state unchanged, div_err=1 for one cycle.
- Apply:
  - At the period boundary (cnt==N-1, en=1) with div_busy=1: div_cur takes the pending value, cnt goes to 0, div_busy clears.
  - A valid div_load in the boundary cycle itself bypasses the pending register: div_in is applied at that boundary and div_busy stays 0.
- Arithmetic:
  - ceil(N/2) = (N+1)>>1, computed at CNT_W+1 bits so it does not overflow at N = 2^CNT_W-1.
  - cnt compares use div_cur only, never pending.

## Timing
- Cycle 0 is the first posedge with reset=1 after reset. Outputs are registered and reflect cnt after that edge.
- N=4 trace:
  - clk_out: 0,0,1,1,0,0,1,1...
  - tick at cycles 2, 6, 10...
  - period = 4 clk cycles.
- A new ratio becomes visible on div_cur in the cycle after the boundary edge. The first period at the new ratio starts with cnt=0, clk_out=0.
- Load-to-apply latency: from 1 cycle (load in the boundary cycle) up to N_old cycles.
- div_err pulses in the cycle after the rejected load edge.
- Reset mid-period or mid-pending: reset wins. The pending value is discarded and the block returns to DEFAULT_DIV.
- Priority order: reset > sync_in > boundary apply > count.

## Configuration
- Macro: CLKDIV_SYNC_EN.
- Defined:
  - port `sync_in` exists;
  - sync_in=1 at a posedge forces cnt=0, clk_out=0, tick=0, regardless of en;
  - any pending ratio is applied immediately and div_busy clears;
  - counting resumes next cycle if en=1.
- Undefined: port `sync_in` absent; behaviour is otherwise identical.

## Test plan
- Reset release, DEFAULT_DIV=4, en=1 for 16 cycles -> clk_out 0011 repeating; tick at cycles 2, 6, 10, 14; div_cur=4.
- Load N=5 at cycle 1 -> div_busy=1 until the boundary at cycle 3; from cycle 4, clk_out 00011 repeating; tick every 5 cycles.
- Load 7, then 3 before the boundary -> only 3 applied; div_busy drops at the boundary.
- div_in=1 with div_load -> div_err pulse; div_cur and div_busy unchanged.
- en low for 3 cycles mid-period at cnt=2, N=4 -> clk_out holds 1, no tick; counting resumes at cnt=3.
- reset=0 during pending N=9 -> cnt=0, clk_out=0, div_cur=4, div_busy=0. With CLKDIV_SYNC_EN: a sync_in pulse at cnt=1 with pending 6 -> next cycle cnt=0, div_cur=6.
